// File: rtl/tinyqv_fetch_pkg.sv
// rtl/tinyqv_fetch_pkg.sv - shared types and constants for the instruction-fetch responder
package tinyqv_fetch_pkg;

  localparam int ADDR_BITS_DEFAULT = 23;
  localparam int HALFWORD_INC      = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DELIVER,
    ST_GAP,
    ST_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/tinyqv_instr_fetch_responder.sv
// rtl/tinyqv_instr_fetch_responder.sv - streams halfwords to the CPU, one memory read at a time
module tinyqv_instr_fetch_responder
  import tinyqv_fetch_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] instr_addr,
  input  logic                 instr_fetch_restart,
  input  logic                 instr_fetch_stall,
  output logic                 instr_fetch_started,
  output logic                 instr_fetch_stopped,
  output logic [15:0]          instr_data_out,
  output logic                 instr_ready,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_req,
  output logic                 mem_seq,
  input  logic                 mem_ack,
  input  logic [15:0]          mem_rdata
);

  fetch_state_e         state_q;
  logic [ADDR_BITS-1:0] fa_q;
  logic [ADDR_BITS-1:0] fa_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [15:0]          data_q;
  logic                 started_q;
  logic                 stopped_q;
  logic                 ready_q;
  logic                 req_q;
  logic                 seq_q;

  assign fa_d = fa_q + ADDR_BITS'(HALFWORD_INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fa_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      started_q <= 1'b0;
      stopped_q <= 1'b0;
      ready_q   <= 1'b0;
      req_q     <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      started_q <= 1'b0;
      stopped_q <= 1'b0;
      ready_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (instr_fetch_restart) begin
            fa_q      <= instr_addr;
            addr_q    <= instr_addr;
            req_q     <= 1'b1;
            seq_q     <= 1'b0;
            started_q <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          // The CPU cannot have seen started yet, so a restart in that cycle is stale.
          if (instr_fetch_restart && !started_q) begin
            if (mem_ack) begin
              req_q   <= 1'b0;
              seq_q   <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else if (mem_ack) begin
            data_q  <= mem_rdata;
            fa_q    <= fa_d;
            req_q   <= 1'b0;
            seq_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          state_q <= instr_fetch_restart ? ST_IDLE : ST_GAP;
        end
        ST_GAP: begin
          if (instr_fetch_restart) begin
            state_q <= ST_IDLE;
          end else if (instr_fetch_stall) begin
            stopped_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            req_q   <= 1'b1;
            addr_q  <= fa_q;
            // A wrapped address is not contiguous with the previous read.
            seq_q   <= (fa_q != '0);
            state_q <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (mem_ack) begin
            req_q   <= 1'b0;
            seq_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_fetch_started = started_q;
  assign instr_fetch_stopped = stopped_q;
  assign instr_data_out      = data_q;
  assign instr_ready         = ready_q;
  assign mem_addr            = addr_q;
  assign mem_req             = req_q;
  assign mem_seq             = seq_q;

endmodule
